// File: rtl/dispenser_ctrl.sv
// Dispenser-side pour engine: runs one motor for qty*UNIT_CYCLES clocks, then raises its done flag.
// Build option SENSOR_PULSE_EN replaces the prescaler with a synchronized flow-sensor pulse input.
module dispenser_ctrl #(
   parameter int unsigned VAL_W       = 8,
   parameter int unsigned UNIT_CYCLES = 50000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rgb_load,
   input  logic [3*VAL_W-1:0] rgb_in,
   input  logic [2:0]         motor_req,
`ifdef SENSOR_PULSE_EN
   input  logic               pulse_in,
`endif
   output logic [2:0]         motor_drive,
   output logic [2:0]         flags,
   output logic               busy,
   output logic               req_err
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [2:0]       ch_q, ch_d;             // active channel, one-hot like motor_req
   logic [VAL_W-1:0] rem_q, rem_d;
   logic [VAL_W-1:0] qty_r_q, qty_g_q, qty_b_q;
   logic [2:0]       motor_drive_q, motor_drive_d;
   logic [2:0]       flags_q, flags_d;
   logic             busy_q, busy_d;
   logic             req_err_q, req_err_d;

   logic             req_multi;
   logic             req_single;
   logic             req_hold;
   logic [VAL_W-1:0] req_qty;
   logic             unit_tick;

   assign req_multi  = (motor_req[2] & motor_req[1]) | (motor_req[2] & motor_req[0]) |
                       (motor_req[1] & motor_req[0]);
   assign req_single = (|motor_req) & ~req_multi;
   assign req_hold   = |(motor_req & ch_q);

   always_comb begin
      req_qty = '0;
      case (motor_req)
         3'b100:  req_qty = qty_r_q;
         3'b010:  req_qty = qty_g_q;
         3'b001:  req_qty = qty_b_q;
         default: req_qty = '0;
      endcase
   end

`ifdef SENSOR_PULSE_EN
   // Two synchronizer stages plus one history stage for rising-edge detection.
   logic [2:0] pulse_sync_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pulse_sync_q <= '0;
      end else begin
         pulse_sync_q <= {pulse_sync_q[1:0], pulse_in};
      end
   end

   assign unit_tick = pulse_sync_q[1] & ~pulse_sync_q[2];
`else
   localparam int unsigned PRESC_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

   logic [PRESC_W-1:0] presc_q, presc_d;

   assign unit_tick = (presc_q == PRESC_W'(UNIT_CYCLES - 1));

   // Counts only while staying in RUN; any entry into RUN starts from zero.
   always_comb begin
      presc_d = '0;
      if (state_q == StRun && state_d == StRun) begin
         presc_d = unit_tick ? '0 : presc_q + PRESC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      rem_d   = rem_q;
      unique case (state_q)
         StIdle: begin
            if (req_single) begin
               ch_d    = motor_req;
               rem_d   = req_qty;
               state_d = (req_qty == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            if (req_multi || !req_hold) begin
               state_d = StIdle;
               rem_d   = '0;
            end else if (unit_tick) begin
               if (rem_q <= VAL_W'(1)) begin
                  rem_d   = '0;
                  state_d = StDone;
               end else begin
                  rem_d = rem_q - VAL_W'(1);
               end
            end
         end
         StDone: begin
            if (req_multi || !req_hold) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state change.
   always_comb begin
      motor_drive_d = (state_d == StRun)  ? ch_d : 3'b000;
      flags_d       = (state_d == StDone) ? ch_d : 3'b000;
      busy_d        = (state_d == StRun);
      req_err_d     = req_multi;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         ch_q          <= '0;
         rem_q         <= '0;
         motor_drive_q <= '0;
         flags_q       <= '0;
         busy_q        <= 1'b0;
         req_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ch_q          <= ch_d;
         rem_q         <= rem_d;
         motor_drive_q <= motor_drive_d;
         flags_q       <= flags_d;
         busy_q        <= busy_d;
         req_err_q     <= req_err_d;
      end
   end

   // Quantities are frozen while a pour is running.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         qty_r_q <= '0;
         qty_g_q <= '0;
         qty_b_q <= '0;
      end else if (rgb_load && !busy_q) begin
         qty_r_q <= rgb_in[3*VAL_W-1:2*VAL_W];
         qty_g_q <= rgb_in[2*VAL_W-1:VAL_W];
         qty_b_q <= rgb_in[VAL_W-1:0];
      end
   end

   assign motor_drive = motor_drive_q;
   assign flags       = flags_q;
   assign busy        = busy_q;
   assign req_err     = req_err_q;

endmodule

// File: tb/tb_dispenser_ctrl.sv
// Self-checking bench for dispenser_ctrl (prescaler build, UNIT_CYCLES=4).
module tb_dispenser_ctrl;

   localparam int unsigned VAL_W = 8;
   localparam int unsigned UNIT  = 4;

   logic               clk       = 1'b0;
   logic               reset     = 1'b1;
   logic               rgb_load  = 1'b0;
   logic [3*VAL_W-1:0] rgb_in    = '0;
   logic [2:0]         motor_req = 3'b000;
   logic [2:0]         motor_drive;
   logic [2:0]         flags;
   logic               busy;
   logic               req_err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0] flag;
      int         cycles;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   dispenser_ctrl #(
      .VAL_W       (VAL_W),
      .UNIT_CYCLES (UNIT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rgb_load    (rgb_load),
      .rgb_in      (rgb_in),
      .motor_req   (motor_req),
      .motor_drive (motor_drive),
      .flags       (flags),
      .busy        (busy),
      .req_err     (req_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      rgb_in   = {r, g, b};
      rgb_load = 1'b1;
      tick();
      rgb_load = 1'b0;
   endtask

   // Issues one request and measures the pour against the queued expectation.
   task automatic pour(input string name, input logic [2:0] req, input int qty, input int load_at);
      exp_t e;
      int   cnt   = 0;
      int   guard = 0;
      bit   stray = 1'b0;
      e.flag   = req;
      e.cycles = qty * UNIT;
      exp_q.push_back(e);
      motor_req = req;
      tick();
      while (flags === 3'b000 && guard < 2000) begin
         if (motor_drive === req && busy === 1'b1) cnt++;
         else stray = 1'b1;
         if (load_at > 0 && cnt == load_at) begin
            rgb_in   = 24'h010101;
            rgb_load = 1'b1;
         end else begin
            rgb_load = 1'b0;
         end
         tick();
         guard++;
      end
      rgb_load = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (flags !== e.flag) begin
         failures++;
         $display("FAIL %s_flags: got %b expected %b", name, flags, e.flag);
      end
      checks++;
      if (cnt !== e.cycles) begin
         failures++;
         $display("FAIL %s_len: got %0d drive cycles expected %0d", name, cnt, e.cycles);
      end
      checks++;
      if (stray !== 1'b0) begin
         failures++;
         $display("FAIL %s_stray: drive/busy wrong during pour, got stray=%b expected 0", name, stray);
      end
      checks++;
      if (motor_drive !== 3'b000 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_done: got drive=%b busy=%b expected 000/0", name, motor_drive, busy);
      end
      motor_req = 3'b000;
      tick();
      checks++;
      if (flags !== 3'b000) begin
         failures++;
         $display("FAIL %s_clear: got flags=%b expected 000", name, flags);
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      #10;
      checks++;
      if (motor_drive !== 3'b000 || flags !== 3'b000 || busy !== 1'b0 || req_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: got drive=%b flags=%b busy=%b err=%b expected all 0",
                  motor_drive, flags, busy, req_err);
      end
      @(negedge clk);
      reset = 1'b1;
      tick();
      pour("reset_qty", 3'b100, 0, -1);
   endtask

   task automatic test_basic();
      load_rgb(8'd3, 8'd0, 8'd0);
      pour("basic", 3'b100, 3, -1);
   endtask

   task automatic test_sequence();
      load_rgb(8'd2, 8'd1, 8'd5);
      pour("seq_r", 3'b100, 2, -1);
      pour("seq_g", 3'b010, 1, -1);
      pour("seq_b", 3'b001, 5, -1);
   endtask

   task automatic test_zero();
      load_rgb(8'd2, 8'd0, 8'd5);
      pour("zero_g", 3'b010, 0, -1);
   endtask

   task automatic test_abort();
      load_rgb(8'd5, 8'd0, 8'd5);
      motor_req = 3'b100;
      tick();
      repeat (6) tick();
      motor_req = 3'b000;
      tick();
      checks++;
      if (motor_drive !== 3'b000 || flags !== 3'b000 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_off: got drive=%b flags=%b busy=%b expected 000/000/0",
                  motor_drive, flags, busy);
      end
      pour("restart", 3'b100, 5, -1);
      // Channel switch mid-pour: one idle cycle, then the new (zero-qty) channel completes.
      motor_req = 3'b100;
      repeat (3) tick();
      motor_req = 3'b010;
      tick();
      checks++;
      if (motor_drive !== 3'b000 || flags !== 3'b000 || busy !== 1'b0) begin
         failures++;
         $display("FAIL switch_idle: got drive=%b flags=%b busy=%b expected 000/000/0",
                  motor_drive, flags, busy);
      end
      tick();
      checks++;
      if (flags !== 3'b010 || motor_drive !== 3'b000) begin
         failures++;
         $display("FAIL switch_new: got flags=%b drive=%b expected 010/000", flags, motor_drive);
      end
      motor_req = 3'b000;
      tick();
   endtask

   task automatic test_error();
      motor_req = 3'b110;
      tick();
      checks++;
      if (req_err !== 1'b1 || motor_drive !== 3'b000 || busy !== 1'b0 || flags !== 3'b000) begin
         failures++;
         $display("FAIL err_idle: got err=%b drive=%b busy=%b flags=%b expected 1/000/0/000",
                  req_err, motor_drive, busy, flags);
      end
      motor_req = 3'b000;
      tick();
      checks++;
      if (req_err !== 1'b0) begin
         failures++;
         $display("FAIL err_clear: got err=%b expected 0", req_err);
      end
      motor_req = 3'b100;
      repeat (2) tick();
      motor_req = 3'b101;
      tick();
      checks++;
      if (req_err !== 1'b1 || motor_drive !== 3'b000 || busy !== 1'b0) begin
         failures++;
         $display("FAIL err_run: got err=%b drive=%b busy=%b expected 1/000/0",
                  req_err, motor_drive, busy);
      end
      motor_req = 3'b000;
      tick();
   endtask

   task automatic test_load_lock();
      pour("lock", 3'b100, 5, 3);
      pour("lock_after", 3'b100, 5, -1);
   endtask

   task automatic test_reset_mid();
      motor_req = 3'b001;
      tick();
      repeat (4) tick();
      #2 reset = 1'b0;
      #1;
      checks++;
      if (motor_drive !== 3'b000 || flags !== 3'b000 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: got drive=%b flags=%b busy=%b expected 000/000/0",
                  motor_drive, flags, busy);
      end
      motor_req = 3'b000;
      @(negedge clk);
      reset = 1'b1;
      tick();
      pour("reset_b", 3'b001, 0, -1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sequence();
      test_zero();
      test_abort();
      test_error();
      test_load_lock();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
